// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared opcodes, loader states and sizing helper for the BNN stream loader
package bnn_pkg;

    typedef enum logic [1:0] {
        OP_WEIGHTS = 2'b00,
        OP_INPUT   = 2'b01
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_X = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/bnn_vec_packer.sv
// rtl/bnn_vec_packer.sv - byte-indexed write register; byte k lands in vec[8k +: 8], overflow bits dropped
module bnn_vec_packer #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] byte_idx,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] vec
);

    always_ff @(posedge clk) begin
        if (rst) begin
            vec <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (byte_idx == IDX_W'(b >> 3))
                    vec[b] <= byte_data[b[2:0]];
            end
        end
    end

endmodule

// File: rtl/bnn_stream_loader.sv
// rtl/bnn_stream_loader.sv - framed byte loader for BNN weights/input; optional trailing XOR check via BNN_LOADER_CHECKSUM_EN
module bnn_stream_loader
    import bnn_pkg::*;
#(
    parameter int INPUT_SIZE  = 784,
    parameter int NUM_NEURONS = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        data_in,
    input  logic                              data_valid,
    output logic                              data_ready,
    output logic [NUM_NEURONS*INPUT_SIZE-1:0] weights,
    output logic [INPUT_SIZE-1:0]             in_vector,
    output logic                              weights_loaded,
    output logic                              input_loaded,
    output logic                              start,
    output logic                              frame_err
);

    localparam int W_BITS  = NUM_NEURONS * INPUT_SIZE;
    localparam int W_BYTES = bytes_for(W_BITS);
    localparam int X_BYTES = bytes_for(INPUT_SIZE);
    localparam int CNT_W   = $clog2(W_BYTES + 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_BYTES - 1);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_BYTES - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             is_input;
    logic             accept;
    logic             last_byte;
    logic             frame_done;

    assign accept    = data_valid && data_ready;
    assign last_byte = accept && ((state == LOAD_W && cnt == W_LAST) ||
                                  (state == LOAD_X && cnt == X_LAST));

`ifdef BNN_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       chk_bad;
    assign frame_done = accept && state == CHK && data_in == csum;
    assign chk_bad    = accept && state == CHK && data_in != csum;
`else
    assign frame_done = last_byte;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            is_input       <= 1'b0;
            data_ready     <= 1'b0;
            weights_loaded <= 1'b0;
            input_loaded   <= 1'b0;
            start          <= 1'b0;
            frame_err      <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            start     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    data_ready <= 1'b1;
                    if (accept) begin
                        cnt <= '0;
`ifdef BNN_LOADER_CHECKSUM_EN
                        csum <= '0;
`endif
                        case (opcode_t'(data_in[1:0]))
                            OP_WEIGHTS: begin
                                state          <= LOAD_W;
                                is_input       <= 1'b0;
                                weights_loaded <= 1'b0;
                            end
                            OP_INPUT: begin
                                state        <= LOAD_X;
                                is_input     <= 1'b1;
                                input_loaded <= 1'b0;
                            end
                            default: frame_err <= 1'b1;
                        endcase
                    end
                end
                LOAD_W, LOAD_X: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
`ifdef BNN_LOADER_CHECKSUM_EN
                        csum <= csum ^ data_in;
                        if (last_byte)
                            state <= CHK;
`endif
                    end
                end
`ifdef BNN_LOADER_CHECKSUM_EN
                CHK: begin
                    // Mismatch drops the frame: written data stays, flag stays low, no start.
                    if (chk_bad) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
`endif
                DONE: begin
                    state      <= IDLE;
                    data_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Completion is registered here so flags and start appear during the DONE cycle.
            if (frame_done) begin
                state      <= DONE;
                data_ready <= 1'b0;
                if (is_input) begin
                    input_loaded <= 1'b1;
                    start        <= weights_loaded;
                end else begin
                    weights_loaded <= 1'b1;
                end
            end
        end
    end

    bnn_vec_packer #(.WIDTH(W_BITS), .IDX_W(CNT_W)) u_w_packer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept && state == LOAD_W),
        .byte_idx  (cnt),
        .byte_data (data_in),
        .vec       (weights)
    );

    bnn_vec_packer #(.WIDTH(INPUT_SIZE), .IDX_W(CNT_W)) u_x_packer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept && state == LOAD_X),
        .byte_idx  (cnt),
        .byte_data (data_in),
        .vec       (in_vector)
    );

endmodule

// File: tb/tb_bnn_stream_loader.sv
// tb/tb_bnn_stream_loader.sv - directed self-checking bench for bnn_stream_loader (12-bit input, 2 neurons)
module tb_bnn_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [23:0] weights;
    logic [11:0] in_vector;
    logic        weights_loaded;
    logic        input_loaded;
    logic        start;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;

`ifdef BNN_LOADER_CHECKSUM_EN
    localparam int TOG_N = 5;
`else
    localparam int TOG_N = 4;
`endif
    logic [7:0] tog [5] = '{8'h00, 8'hC3, 8'h96, 8'h69, 8'h3C};

    always #5 clk = ~clk;

    bnn_stream_loader #(.INPUT_SIZE(12), .NUM_NEURONS(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .weights        (weights),
        .in_vector      (in_vector),
        .weights_loaded (weights_loaded),
        .input_loaded   (input_loaded),
        .start          (start),
        .frame_err      (frame_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", data_ready, 1);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic frame_tail(input logic [7:0] x);
`ifdef BNN_LOADER_CHECKSUM_EN
        send_byte(x);
`else
        if (x === 8'hxx) $display("unused tail");
`endif
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",   data_ready, 0);
        check("rst_weights", weights, 0);
        check("rst_invec",   in_vector, 0);
        check("rst_wl",      weights_loaded, 0);
        check("rst_il",      input_loaded, 0);
        check("rst_start",   start, 0);
        check("rst_err",     frame_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", data_ready, 1);

        // Weight frame back-to-back
        send_byte(8'h00);
        check("w1_wl_hdr", weights_loaded, 0);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hF0);
        frame_tail(8'h69);
        check("w1_weights", weights, 24'hF03CA5);
        check("w1_wl",      weights_loaded, 1);
        check("w1_start",   start, 0);
        check("w1_done_rdy", data_ready, 0);
        @(negedge clk);
        check("w1_idle_rdy", data_ready, 1);

        // Input frame with weights present: start pulses once
        send_byte(8'h01);
        check("x1_il_hdr", input_loaded, 0);
        send_byte(8'hFF);
        send_byte(8'hFE);
        frame_tail(8'h01);
        check("x1_invec", in_vector, 12'hEFF);
        check("x1_il",    input_loaded, 1);
        check("x1_start", start, 1);
        @(negedge clk);
        check("x1_start_off", start, 0);
        check("x1_wl_kept",   weights_loaded, 1);
        check("x1_w_kept",    weights, 24'hF03CA5);

        // Illegal header
        send_byte(8'h02);
        check("bad_err",   frame_err, 1);
        check("bad_ready", data_ready, 1);
        check("bad_il",    input_loaded, 1);
        @(negedge clk);
        check("bad_err_off", frame_err, 0);
        send_byte(8'h01);
        send_byte(8'h34);
        check("x2_partial", in_vector, 12'hE34);
        check("x2_il_partial", input_loaded, 0);
        send_byte(8'h02);
        frame_tail(8'h36);
        check("x2_invec", in_vector, 12'h234);
        check("x2_start", start, 1);
        @(negedge clk);

        // Input before weights: no start, and a following weight frame gives no start
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h03);
        frame_tail(8'h59);
        check("x3_invec", in_vector, 12'h35A);
        check("x3_il",    input_loaded, 1);
        check("x3_start", start, 0);
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        frame_tail(8'h00);
        check("w3_weights", weights, 24'h332211);
        check("w3_start",   start, 0);
        check("w3_il_kept", input_loaded, 1);
        @(negedge clk);
        check("w3_start_off", start, 0);

        // data_valid toggling every cycle
        for (int i = 0; i < TOG_N; i++) begin
            check("tog_ready_pre", data_ready, 1);
            data_in    = tog[i];
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            check("tog_ready_post", data_ready, (i < TOG_N - 1) ? 1 : 0);
            @(negedge clk);
        end
        check("tog_weights", weights, 24'h6996C3);
        check("tog_wl",      weights_loaded, 1);

        // Reset mid-frame
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        check("mid_partial", weights, 24'h693412);
        rst = 1'b1;
        @(negedge clk);
        check("mid_weights", weights, 0);
        check("mid_invec",   in_vector, 0);
        check("mid_wl",      weights_loaded, 0);
        check("mid_il",      input_loaded, 0);
        check("mid_ready",   data_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        frame_tail(8'h89);
        check("fresh_weights", weights, 24'hEFCDAB);
        check("fresh_wl",      weights_loaded, 1);
        @(negedge clk);

`ifdef BNN_LOADER_CHECKSUM_EN
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("ck_good_il",    input_loaded, 1);
        check("ck_good_invec", in_vector, 12'h201);
        check("ck_good_start", start, 1);
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        check("ck_bad_err",   frame_err, 1);
        check("ck_bad_il",    input_loaded, 0);
        check("ck_bad_start", start, 0);
        @(negedge clk);
        check("ck_bad_il2",   input_loaded, 0);
        check("ck_bad_start2", start, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bnn_stream_loader.md
Name: bnn_stream_loader

Overview:
- Byte-serial front end that writes the operand vectors read by the binary MLP classification layer.
- Receives framed bytes over a valid/ready handshake and packs them LSB-first into two registers:
  - the flat weight matrix, NUM_NEURONS*INPUT_SIZE bits;
  - the binary input vector, INPUT_SIZE bits.
- Raises per-vector loaded flags and a one-cycle start pulse, so the combinational classifier and argmax see stable, complete operands.

Parameters:
- INPUT_SIZE, 784, bits per input vector and per neuron weight vector.
- NUM_NEURONS, 10, neuron count; weight register width is NUM_NEURONS*INPUT_SIZE.
- W_BYTES, ceil(NUM_NEURONS*INPUT_SIZE/8), weight payload bytes (derived; do not override).
- X_BYTES, ceil(INPUT_SIZE/8), input payload bytes (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  8  stream byte.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  loader accepts a byte; transfer occurs when data_valid && data_ready.
- weights  out  NUM_NEURONS*INPUT_SIZE  packed weights; neuron n occupies [n*INPUT_SIZE +: INPUT_SIZE].
- in_vector  out  INPUT_SIZE  packed input vector.
- weights_loaded  out  1  weight register holds a complete frame.
- input_loaded  out  1  input register holds a complete frame.
- start  out  1  one-cycle pulse when an input frame completes while weights_loaded=1.
- frame_err  out  1  one-cycle pulse on a bad header (or a bad checksum, see Optional Feature).

Behaviour:
- Reset: state=IDLE; all registers and outputs 0; data_ready=0 during the reset cycle.
- Frame format: header byte, then payload bytes LSB-first.
  - Header bits[1:0]: 00 = weights, 01 = input, 10/11 = illegal. Bits[7:2] are ignored.
  - Payload byte k writes register bits [8k +: 8]. Bits at or beyond the register width in the final byte are discarded.
- FSM states: IDLE, LOAD_W, LOAD_X, DONE.
  - IDLE: data_ready=1.
    - Header 00 -> LOAD_W; weights_loaded<=0; byte counter<=0.
    - Header 01 -> LOAD_X; input_loaded<=0; counter<=0.
    - Illegal header -> stay in IDLE; frame_err pulses next cycle.
  - LOAD_W / LOAD_X: data_ready=1. Each accepted byte writes the slice and increments the counter.
    - On the byte where counter==W_BYTES-1 (or X_BYTES-1) -> DONE.
  - DONE: data_ready=0 for exactly one cycle.
    - Set the matching loaded flag.
    - If the frame was an input frame and weights_loaded=1, start=1 this cycle.
    - Then -> IDLE.
- Handshake rules:
  - No transfer while data_valid=0; the counter holds and the FSM holds.
  - data_ready does not depend combinationally on data_valid.
- Register contents:
  - Unwritten bits keep their previous value during a partial load.
  - A loaded flag stays 0 until that frame completes.
  - Loading weights never clears input_loaded, and loading input never clears weights_loaded.
- Counter width: $clog2(W_BYTES+1); X_BYTES fits in the same counter.
- Reset mid-frame: abort immediately to reset values; a partial frame is never flagged as loaded.
- Latency: start asserts 1 cycle after the final payload byte is accepted.

Optional Feature:
- Macro: BNN_LOADER_CHECKSUM_EN.
- Defined:
  - Each frame carries one extra trailing byte equal to the XOR of all payload bytes; the header is excluded.
  - The FSM adds a CHK state between the final payload byte and DONE.
  - On mismatch: pulse frame_err, leave the loaded flag at 0, skip DONE (no start), return to IDLE.
  - Register contents keep the written data.
- Undefined: no CHK state; frames are header plus payload only.

Decomposition:
- Package bnn_pkg:
  - opcode enum: OP_WEIGHTS=2'b00, OP_INPUT=2'b01.
  - loader state enum.
  - function bytes_for(bits) returning ceil(bits/8).
- One natural sub-module, bnn_vec_packer #(WIDTH):
  - Byte-indexed write register with ports clk, rst, wr_en, byte_idx, byte_data, vec.
  - Instantiated twice: weights and in_vector.
- FSM and counter live in the top module.

Test Plan (INPUT_SIZE=12, NUM_NEURONS=2, W_BYTES=3, X_BYTES=2):
- Header 0x00, then 0xA5, 0x3C, 0xF0 -> weights=24'hF03CA5; weights_loaded=1 one cycle after the last byte; start=0.
- After the above: header 0x01, then 0xFF, 0xFE -> in_vector=12'hEFF (bits 15:12 dropped); input_loaded=1; start pulses exactly one cycle.
- Input frame sent before any weight frame -> input_loaded=1, start stays 0. A following weight frame also gives start=0.
- Header 0x02 -> frame_err pulses once; state stays IDLE; next header 0x01 loads normally.
- data_valid toggled 1/0 every cycle during a weight frame -> same final weights as back-to-back; data_ready=0 only in the DONE cycle.
- rst asserted after the 2nd weight byte -> all outputs 0 next cycle; a fresh full frame then loads correctly.
- With BNN_LOADER_CHECKSUM_EN: payload 0x01, 0x02 plus checksum 0x03 -> loaded. Checksum 0x00 -> frame_err pulses, no loaded flag, no start.
